branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The port list SHALL be, one per line (name direction width meaning), clock and reset first:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid_e  in  1  execute-stage instruction valid
- i_stall_e  in  1  execute stalled; instruction re-presented next cycle
- i_is_branch_e  in  1  conditional branch
- i_is_jump_e  in  1  JAL/JALR
- i_br_cond_e  in  1  branch comparator result
- i_target_e  in  32  computed target from the ALU
- i_pc_four_e  in  32  PC+4 of the execute instruction
- i_pred_taken_e  in  1  taken flag predicted at fetch
- i_pred_pc_e  in  32  PC predicted at fetch
- o_redirect  out  1  one-cycle PC redirect pulse to fetch
- o_redirect_pc  out  32  correct next PC
- o_flush_d  out  1  flush the fetch-to-decode register
- o_flush_e  out  1  flush the decode-to-execute register
- o_upd_valid  out  1  one-cycle predictor update strobe
- o_upd_taken  out  1  actual outcome
- o_upd_jump  out  1  resolved instruction was a jump
- o_upd_target  out  32  actual target
- o_upd_mispredict  out  1  misprediction flag for the predictor
- o_busy  out  1  FSM is in RECOVER
- o_br_cnt  out  32  resolved branch/jump count (macro-gated)
- o_mispred_cnt  out  32  misprediction count (macro-gated)

Function
REQ-003 A resolve event SHALL occur when i_valid_e=1, i_stall_e=0 and the state is IDLE.
REQ-004 The actual outcome SHALL be taken = i_is_jump_e | (i_is_branch_e & i_br_cond_e).
REQ-005 A mispredict SHALL be flagged when taken differs from i_pred_taken_e, or when both are 1 and i_target_e differs from i_pred_pc_e (32-bit compare).
REQ-006 The correct PC SHALL be i_target_e when taken, otherwise i_pc_four_e.
REQ-007 Predictor update outputs:
- A resolve event on a branch, a jump, or any instruction with i_pred_taken_e=1 SHALL register o_upd_* at the next edge.
- o_upd_valid SHALL be high for exactly one cycle.
- For a non-branch with i_pred_taken_e=1: o_upd_taken=0 and o_upd_mispredict=1.
REQ-008 The FSM SHALL have two states, IDLE and RECOVER.
- IDLE to RECOVER on a mispredicting resolve event.
- RECOVER to IDLE unconditionally after one cycle.
REQ-009 Mispredict detected in cycle N SHALL produce, in cycle N+1 only: o_redirect=1, o_redirect_pc = correct PC, o_flush_d=1, o_flush_e=1.
REQ-010 In RECOVER, i_valid_e SHALL be ignored: no update, no redirect, no count. The instruction then in execute is wrong-path.
REQ-011 o_busy SHALL equal (state==RECOVER).
REQ-012 i_stall_e=1 SHALL suppress resolution that cycle. A mispredict under stall is resolved on the first unstalled cycle.
REQ-013 Correct predictions SHALL NOT assert o_redirect or the flush outputs.
REQ-014 i_valid_e=0 SHALL produce no outputs, regardless of the other inputs.
REQ-015 All outputs SHALL be registered; latency from a resolve event to the outputs is 1 cycle.

Reset
REQ-016 i_rst=1 SHALL immediately force state IDLE and drive every output to 0, including o_redirect_pc, o_upd_target and both counters.
REQ-017 Reset asserted during RECOVER SHALL cancel the pending redirect; no pulse is issued after reset deasserts.

Configuration
REQ-018 With macro BRU_PERF_CNT_EN defined:
- o_br_cnt SHALL increment on each branch/jump resolve event.
- o_mispred_cnt SHALL increment on each mispredict.
- Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-019 Without BRU_PERF_CNT_EN, o_br_cnt and o_mispred_cnt SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Branch, cond=1, pred_taken=1, pred_pc=target=0x100 -> o_upd_valid=1, taken=1, mispredict=0; no redirect; state stays IDLE.
- Branch, cond=1, pred_taken=0, target=0x200 -> next cycle o_redirect=1, o_redirect_pc=0x200, o_flush_d=o_flush_e=1, o_busy=1; the following cycle all are 0.
- Jump, pred_taken=1, pred_pc=0x300, target=0x340 -> redirect to 0x340, o_upd_jump=1, o_upd_mispredict=1.
- Non-branch, pred_taken=1, pc_four=0x44 -> redirect to 0x44, o_upd_taken=0; a valid mispredicting branch presented during RECOVER is ignored.
- Mispredicting branch with i_stall_e=1 for 3 cycles -> no outputs until stall drops, then exactly one redirect; i_rst pulsed in RECOVER -> all outputs 0 immediately, no redirect afterwards.
- With BRU_PERF_CNT_EN: 5 branches, 2 mispredicted -> o_br_cnt=5, o_mispred_cnt=2. Without the macro -> both read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: detects mispredictions, issues a one-cycle redirect/flush,
// and strobes predictor updates. Optional performance counters are enabled by BRU_PERF_CNT_EN.
module branch_resolve_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid_e,
  input  logic        i_stall_e,
  input  logic        i_is_branch_e,
  input  logic        i_is_jump_e,
  input  logic        i_br_cond_e,
  input  logic [31:0] i_target_e,
  input  logic [31:0] i_pc_four_e,
  input  logic        i_pred_taken_e,
  input  logic [31:0] i_pred_pc_e,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush_d,
  output logic        o_flush_e,
  output logic        o_upd_valid,
  output logic        o_upd_taken,
  output logic        o_upd_jump,
  output logic [31:0] o_upd_target,
  output logic        o_upd_mispredict,
  output logic        o_busy,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t      state_q, state_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        recover_flush_q, recover_flush_d;
  logic        upd_valid_q, upd_valid_d;
  logic        upd_taken_q, upd_taken_d;
  logic        upd_jump_q, upd_jump_d;
  logic [31:0] upd_target_q, upd_target_d;
  logic        upd_mispredict_q, upd_mispredict_d;

  logic        resolve;
  logic        taken;
  logic        mispredict;
  logic        is_cti;
  logic [31:0] correct_pc;

  // Instructions arriving while RECOVER is active are wrong-path and never resolve.
  assign resolve    = i_valid_e & ~i_stall_e & (state_q == IDLE);
  assign is_cti     = i_is_branch_e | i_is_jump_e;
  assign taken      = i_is_jump_e | (i_is_branch_e & i_br_cond_e);
  assign mispredict = (taken != i_pred_taken_e) |
                      (taken & i_pred_taken_e & (i_target_e != i_pred_pc_e));
  assign correct_pc = taken ? i_target_e : i_pc_four_e;

  always_comb begin
    state_d          = IDLE;
    redirect_d       = 1'b0;
    redirect_pc_d    = 32'd0;
    recover_flush_d  = 1'b0;
    upd_valid_d      = 1'b0;
    upd_taken_d      = 1'b0;
    upd_jump_d       = 1'b0;
    upd_target_d     = 32'd0;
    upd_mispredict_d = 1'b0;
    if (resolve && mispredict) begin
      state_d         = RECOVER;
      redirect_d      = 1'b1;
      redirect_pc_d   = correct_pc;
      recover_flush_d = 1'b1;
    end
    if (resolve && (is_cti || i_pred_taken_e)) begin
      upd_valid_d      = 1'b1;
      upd_taken_d      = taken;
      upd_jump_d       = i_is_jump_e;
      upd_target_d     = i_target_e;
      upd_mispredict_d = mispredict;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= IDLE;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= 32'd0;
      recover_flush_q  <= 1'b0;
      upd_valid_q      <= 1'b0;
      upd_taken_q      <= 1'b0;
      upd_jump_q       <= 1'b0;
      upd_target_q     <= 32'd0;
      upd_mispredict_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      redirect_q       <= redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      recover_flush_q  <= recover_flush_d;
      upd_valid_q      <= upd_valid_d;
      upd_taken_q      <= upd_taken_d;
      upd_jump_q       <= upd_jump_d;
      upd_target_q     <= upd_target_d;
      upd_mispredict_q <= upd_mispredict_d;
    end
  end

  assign o_redirect       = redirect_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_flush_d        = recover_flush_q;
  assign o_flush_e        = recover_flush_q;
  assign o_upd_valid      = upd_valid_q;
  assign o_upd_taken      = upd_taken_q;
  assign o_upd_jump       = upd_jump_q;
  assign o_upd_target     = upd_target_q;
  assign o_upd_mispredict = upd_mispredict_q;
  assign o_busy           = (state_q == RECOVER);

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Both counters hold at all-ones rather than wrapping.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && is_cti && (br_cnt_q != 32'hFFFF_FFFF))
      br_cnt_d = br_cnt_q + 32'd1;
    if (resolve && mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt_q      <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`else
  assign o_br_cnt      = 32'd0;
  assign o_mispred_cnt = 32'd0;
`endif

endmodule
